// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage MIPS core.
// Captures decoded control, operands and instruction fields each cycle,
// resolves the destination register (rt/rd/$31) and inserts a bubble on
// flush. With ID_EX_HAZARD_DETECT_EN defined it also detects load-use
// hazards, raises stall and keeps a saturating stall-cycle counter;
// otherwise stall and stall_count are tied to zero.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic              id_j_jump,
    input  logic [3:0]        id_alu_op,
    input  logic [1:0]        id_jump,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic              flush,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_j_jump,
    output logic [3:0]        ex_alu_op,
    output logic [1:0]        ex_jump,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [4:0]        ex_write_reg,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic [4:0] dest_reg;

    // Destination: jal links to $31, RegDst=1 selects rt, otherwise rd
    always_comb begin
        dest_reg = id_rd;
        if (id_jump == 2'b11)
            dest_reg = 5'd31;
        else if (id_reg_dst)
            dest_reg = id_rt;
    end

`ifdef ID_EX_HAZARD_DETECT_EN
    logic uses_rt;
    logic hazard;

    // Load in EX whose result is needed by the instruction in ID; $0 never hazards
    always_comb begin
        uses_rt = !id_alu_src || id_mem_write;
        hazard  = ex_valid && ex_mem_read && (ex_write_reg != 5'd0) &&
                  ((ex_write_reg == id_rs) || ((ex_write_reg == id_rt) && uses_rt));
    end

    assign stall = hazard && !flush;

    // Saturating count of load-use stall cycles, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end
`else
    assign stall       = 1'b0;
    assign stall_count = '0;
`endif

    // Pipeline register: reset and bubble share the all-zero state, so
    // reset, flush and stall collapse into one branch ahead of capture
    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_j_jump     <= 1'b0;
            ex_alu_op     <= '0;
            ex_jump       <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_shamt      <= '0;
            ex_rdata1     <= '0;
            ex_rdata2     <= '0;
            ex_imm        <= '0;
            ex_pc_plus4   <= '0;
            ex_write_reg  <= '0;
            ex_valid      <= 1'b0;
        end else begin
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_branch     <= id_branch;
            ex_reg_dst    <= id_reg_dst;
            ex_alu_src    <= id_alu_src;
            ex_j_jump     <= id_j_jump;
            ex_alu_op     <= id_alu_op;
            ex_jump       <= id_jump;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_shamt      <= id_shamt;
            ex_rdata1     <= id_rdata1;
            ex_rdata2     <= id_rdata2;
            ex_imm        <= id_imm;
            ex_pc_plus4   <= id_pc_plus4;
            ex_write_reg  <= dest_reg;
            ex_valid      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random stimulus for id_ex_stage, checked
// against an instruction-level reference model. Two instances share the
// inputs: the default CNT_W=16 build and a CNT_W=2 build for saturation.
// Hazard expectations follow ID_EX_HAZARD_DETECT_EN as seen by the bench.
module tb_id_ex_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        reg_dst;
        logic        alu_src;
        logic        j_jump;
        logic [3:0]  alu_op;
        logic [1:0]  jump;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc4;
    } instr_t;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;
    instr_t id;

    // primary instance outputs
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_reg_dst, ex_alu_src, ex_j_jump;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_jump;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_write_reg;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc_plus4;
    logic        ex_valid, stall;
    logic [15:0] stall_count;

    // narrow-counter instance outputs
    logic        s_reg_write, s_mem_to_reg, s_mem_read, s_mem_write;
    logic        s_branch, s_reg_dst, s_alu_src, s_j_jump;
    logic [3:0]  s_alu_op;
    logic [1:0]  s_jump;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt, s_write_reg;
    logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc_plus4;
    logic        s_valid, s_stall;
    logic [1:0]  s_stall_count;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .id_reg_write(id.reg_write), .id_mem_to_reg(id.mem_to_reg),
        .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
        .id_branch(id.branch), .id_reg_dst(id.reg_dst),
        .id_alu_src(id.alu_src), .id_j_jump(id.j_jump),
        .id_alu_op(id.alu_op), .id_jump(id.jump),
        .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_shamt(id.shamt),
        .id_rdata1(id.rdata1), .id_rdata2(id.rdata2),
        .id_imm(id.imm), .id_pc_plus4(id.pc4),
        .flush(flush),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_reg_dst(ex_reg_dst),
        .ex_alu_src(ex_alu_src), .ex_j_jump(ex_j_jump),
        .ex_alu_op(ex_alu_op), .ex_jump(ex_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
        .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset),
        .id_reg_write(id.reg_write), .id_mem_to_reg(id.mem_to_reg),
        .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
        .id_branch(id.branch), .id_reg_dst(id.reg_dst),
        .id_alu_src(id.alu_src), .id_j_jump(id.j_jump),
        .id_alu_op(id.alu_op), .id_jump(id.jump),
        .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_shamt(id.shamt),
        .id_rdata1(id.rdata1), .id_rdata2(id.rdata2),
        .id_imm(id.imm), .id_pc_plus4(id.pc4),
        .flush(flush),
        .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
        .ex_branch(s_branch), .ex_reg_dst(s_reg_dst),
        .ex_alu_src(s_alu_src), .ex_j_jump(s_j_jump),
        .ex_alu_op(s_alu_op), .ex_jump(s_jump),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_shamt(s_shamt),
        .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2),
        .ex_imm(s_imm), .ex_pc_plus4(s_pc_plus4),
        .ex_write_reg(s_write_reg), .ex_valid(s_valid),
        .stall(s_stall), .stall_count(s_stall_count)
    );

    // reference model: the instruction sitting in EX, plus stall tallies
    instr_t m_ex;
    logic [4:0] m_wr;
    logic m_valid;
    bit   m_known;
    int   m_cnt16, m_cnt2;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] dest_of(input instr_t i);
        if (i.jump == 2'b11) return 5'd31;
        if (i.reg_dst) return i.rt;
        return i.rd;
    endfunction

    function automatic bit hazard_of(input instr_t i);
        bit needs_rt;
        if (!HAZ_EN || !m_valid || !m_ex.mem_read || m_wr == 5'd0) return 1'b0;
        needs_rt = !i.alu_src || i.mem_write;
        return (m_wr == i.rs) || (needs_rt && m_wr == i.rt);
    endfunction

    function automatic instr_t rnd_data(input instr_t i);
        instr_t r = i;
        r.rdata1 = $urandom; r.rdata2 = $urandom; r.pc4 = $urandom & 32'hFFFF_FFFC;
        r.shamt  = 5'($urandom_range(0, 31));
        return r;
    endfunction

    function automatic instr_t mk_r(input int rs, input int rt, input int rd);
        instr_t i = '0;
        i.reg_write = 1; i.alu_op = 4'b0010;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        return rnd_data(i);
    endfunction

    function automatic instr_t mk_lw(input int rs, input int rt);
        instr_t i = '0;
        i.reg_write = 1; i.mem_to_reg = 1; i.mem_read = 1; i.reg_dst = 1; i.alu_src = 1;
        i.rs = 5'(rs); i.rt = 5'(rt); i.imm = 32'h0000_0010;
        return rnd_data(i);
    endfunction

    function automatic instr_t mk_sw(input int rs, input int rt);
        instr_t i = '0;
        i.mem_write = 1; i.alu_src = 1;
        i.rs = 5'(rs); i.rt = 5'(rt); i.imm = 32'h0000_0004;
        return rnd_data(i);
    endfunction

    function automatic instr_t mk_addi(input int rs, input int rt, input logic [31:0] imm);
        instr_t i = '0;
        i.reg_write = 1; i.reg_dst = 1; i.alu_src = 1; i.alu_op = 4'b0001;
        i.rs = 5'(rs); i.rt = 5'(rt); i.imm = imm;
        return rnd_data(i);
    endfunction

    function automatic instr_t mk_jal(input int rd);
        instr_t i = '0;
        i.reg_write = 1; i.j_jump = 1; i.jump = 2'b11; i.rd = 5'(rd);
        return rnd_data(i);
    endfunction

    function automatic instr_t mk_rand();
        instr_t i;
        i = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        i.mem_read = ($urandom_range(0, 1) == 1);
        return i;
    endfunction

    // one clock: drive ID, check combinational stall, clock, check EX state
    task automatic step(input string tag, input instr_t i, input bit fl, input bit rst);
        bit exp_stall;
        id = i; flush = fl; reset = rst;
        #1;
        exp_stall = hazard_of(i) && !fl;
        if (m_known) chk({tag, ".stall"}, 256'(stall), 256'(exp_stall));
        @(posedge clk);
        if (rst) begin
            m_ex = '0; m_wr = '0; m_valid = 0; m_cnt16 = 0; m_cnt2 = 0;
        end else if (fl || exp_stall) begin
            m_ex = '0; m_wr = '0; m_valid = 0;
            if (exp_stall) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else begin
            m_ex = i; m_wr = dest_of(i); m_valid = 1;
        end
        m_known = 1;
        #1;
        chk({tag, ".ex"}, 256'({ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                                ex_branch, ex_reg_dst, ex_alu_src, ex_j_jump, ex_alu_op,
                                ex_jump, ex_rs, ex_rt, ex_rd, ex_shamt, ex_rdata1,
                                ex_rdata2, ex_imm, ex_pc_plus4}), 256'(m_ex));
        chk({tag, ".wr"}, 256'(ex_write_reg), 256'(m_wr));
        chk({tag, ".valid"}, 256'(ex_valid), 256'(m_valid));
        chk({tag, ".cnt"}, 256'(stall_count), 256'(m_cnt16));
        chk({tag, ".cnt2"}, 256'(s_stall_count), 256'(m_cnt2));
    endtask

    initial begin
        m_known = 0; m_valid = 0; m_ex = '0; m_wr = '0; m_cnt16 = 0; m_cnt2 = 0;
        id = '0; flush = 0; reset = 1;
        @(posedge clk); #1;

        // reset with random inputs for two cycles
        step("rst0", mk_rand(), $urandom_range(0, 1) == 1, 1);
        step("rst1", mk_rand(), 0, 1);
        chk("rst.all", 256'({ex_valid, ex_write_reg, ex_alu_op, ex_imm, stall_count}), 256'(0));

        // plain addi capture
        step("addi", mk_addi(0, 8, 32'h0000_FFFF), 0, 0);
        chk("addi.wr8", 256'(ex_write_reg), 256'(8));
        chk("addi.imm", 256'(ex_imm), 256'(32'h0000_FFFF));
        chk("addi.op", 256'(ex_alu_op), 256'(4'b0001));

        // jal links to $31
        step("jal", mk_jal(5), 0, 0);
        chk("jal.wr31", 256'(ex_write_reg), 256'(31));
        chk("jal.jump", 256'(ex_jump), 256'(2'b11));

        // load-use via rs, then held add captured
        step("lw9a", mk_lw(1, 9), 0, 0);
        step("add_rs", mk_r(9, 3, 10), 0, 0);
        step("add_rs2", mk_r(9, 3, 10), 0, 0);

        // load-use via rt with a store consumer
        step("lw9b", mk_lw(1, 9), 0, 0);
        step("sw_rt", mk_sw(2, 9), 0, 0);
        step("sw_rt2", mk_sw(2, 9), 0, 0);

        // addi writing rt: no use of rt, no stall
        step("lw9c", mk_lw(1, 9), 0, 0);
        step("addi_nouse", mk_addi(0, 9, 32'h0000_0009), 0, 0);

        // flush overrides a hazard
        step("lw9d", mk_lw(1, 9), 0, 0);
        step("flush_hz", mk_r(9, 3, 10), 1, 0);

        // $0 load never stalls
        step("lw0", mk_lw(1, 0), 0, 0);
        step("use0", mk_r(0, 0, 11), 0, 0);

        // back-to-back dependent loads
        step("lw10", mk_lw(1, 10), 0, 0);
        step("lw11", mk_lw(10, 11), 0, 0);
        step("lw11b", mk_lw(10, 11), 0, 0);
        step("lw12", mk_lw(11, 12), 0, 0);
        step("lw12b", mk_lw(11, 12), 0, 0);

        // five more separate stalls drive the 2-bit counter into saturation
        for (int n = 0; n < 5; n++) begin
            step("sat_lw", mk_lw(1, 7), 0, 0);
            step("sat_use", mk_r(7, 7, 6), 0, 0);
            step("sat_go", mk_r(7, 7, 6), 0, 0);
        end

        // reset asserted while a hazard is present
        step("mid_lw", mk_lw(1, 9), 0, 0);
        step("mid_rst", mk_r(9, 3, 10), 0, 1);
        step("post_rst", mk_r(9, 3, 10), 0, 0);

        // random traffic over a small register set
        for (int n = 0; n < 400; n++)
            step("rand", mk_rand(), $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with built-in load-use hazard detection for the five-stage MIPS core. It captures the decoded control bits from `control` together with register operands, immediate, register numbers and PC+4 at each rising edge and presents them to the EX stage. It resolves the destination register, including rt/rd selection and $31 for jal, and feeds it back as `previous_rd` to `control` for JR forwarding. It inserts a one-cycle bubble and stalls PC and IF/ID on a load-use dependency; a branch or jump flush overrides everything.

## Interface
- `DATA_W`, 32, datapath width (operands, immediate, PC+4)
- `CNT_W`, 16, width of stall performance counter
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `id_reg_write`, `id_mem_to_reg`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_reg_dst`, `id_alu_src`, `id_j_jump` in 1 each: control bits from decode
- `id_alu_op` in 4: ALU operation code from decode
- `id_jump` in 2: 00 none, 01 jr, 10 jr-forwarded, 11 jal
- `id_rs`, `id_rt`, `id_rd`, `id_shamt` in 5 each: instruction fields
- `id_rdata1`, `id_rdata2`, `id_imm`, `id_pc_plus4` in DATA_W: register file data, sign-extended immediate, PC+4
- `flush` in 1: kill the instruction currently in ID (taken branch or jump)
- `ex_*` out: registered copies of every `id_*` input above, same widths
- `ex_write_reg` out 5: resolved destination register; also drives `control.previous_rd`
- `ex_valid` out 1: 1 = real instruction in EX, 0 = bubble
- `stall` out 1: hold PC and IF/ID this cycle
- `stall_count` out CNT_W: saturating count of load-use stall cycles

## Operation
- Destination: `id_jump==2'b11` -> 31; else `id_reg_dst==1` -> `id_rt`; else `id_rd`. This is the codebase convention: RegDst=1 selects rt for I-type.
- Uses-rt rule: `!id_alu_src || id_mem_write`. This covers R-type, beq/bne and sw.
- Load-use hazard is asserted when `ex_valid && ex_mem_read && ex_write_reg!=0`, and `ex_write_reg==id_rs` or (`ex_write_reg==id_rt` and uses-rt) holds.
- `stall = hazard && !flush`. This is combinational from EX state and ID inputs.
- Register update per edge, in priority order:
  1. `reset`: all `ex_*` = 0, `ex_valid`=0, `ex_write_reg`=0, `stall_count`=0.
  2. `flush`: load bubble.
  3. `stall`: load bubble. The instruction stays in ID, held upstream.
  4. Otherwise: capture all `id_*`, set `ex_write_reg` to the resolved destination, set `ex_valid`=1.
- Bubble contents: all control outputs 0, `ex_alu_op`=0, `ex_jump`=0, `ex_write_reg`=0, `ex_valid`=0. Data fields are don't-care; the implementation zeroes them.
- `stall_count` increments on each edge where `stall`=1, saturates at all-ones, and clears only on reset.
- Register $0 never triggers a hazard.

## Timing
- Capture latency: 1 cycle from ID inputs to `ex_*`.
- `stall` is valid within the same cycle as the ID inputs; there is no registered delay.
- A load-use dependency produces exactly one stall cycle. After the bubble, `ex_mem_read`=0, so `stall` drops the next cycle and the held instruction is captured.
- Back-to-back loads each dependent on the previous one give one stall per pair, with no deadlock.
- Flush and hazard in the same cycle: `stall`=0, bubble loaded, `stall_count` unchanged.
- Reset asserted mid-stall: `stall` still evaluates combinationally from EX state. Because EX clears at that edge, `stall`=0 the following cycle.
- All outputs are 0 during and immediately after reset.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` defined: hazard detection, `stall` and `stall_count` behave as specified above.
- Not defined: `stall` is tied 0 and `stall_count` is tied 0 with no counter flops. The block is a plain pipeline register with flush. Load-use correctness then relies on the compiler inserting nops.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all outputs 0 and `ex_valid`=0 on the first post-reset cycle.
- Plain capture: addi with `id_reg_dst`=1, `id_rt`=8, `id_imm`=0x0000FFFF -> next cycle `ex_write_reg`=8, `ex_imm`=0x0000FFFF, `ex_alu_op`=4'b0001, `ex_valid`=1.
- jal: `id_jump`=2'b11, `id_rd`=5 -> `ex_write_reg`=31, `ex_jump`=2'b11.
- Load-use, rs then rt: `lw $9` in EX, then `add $10,$9,$3` in ID -> `stall`=1 for one cycle, bubble in EX, `add` captured next cycle, `stall_count`=1. Repeat with `sw $9` as rt consumer -> stall. `addi $4,$0,$9`-style non-use of rt -> no stall.
- Flush priority: same load-use setup with `flush`=1 -> `stall`=0, bubble loaded, `stall_count` unchanged. A `$0` destination load produces no stall.
- Saturation, with a small CNT_W=2 build: 5 separate load-use stalls -> `stall_count`=3. With the macro undefined, the same stimulus -> `stall`=0 always.
